// File: rtl/tx_byte_sequencer_if.sv
// Signal bundle between the message sequencer, the pushbutton/host side and the UART transmitter.
// Modports: master drives requests and buffer writes; slave is the sequencer itself.
interface tx_byte_sequencer_if #(
  parameter int AW = 3
);
  logic          send_next;
  logic          burst;
  logic [AW-1:0] last_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          tx_done;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          busy;
  logic [AW-1:0] byte_idx;

  modport master (
    output send_next, burst, last_idx, wr_en, wr_addr, wr_data, tx_done,
    input  trmt, tx_data, busy, byte_idx
  );

  modport slave (
    input  send_next, burst, last_idx, wr_en, wr_addr, wr_data, tx_done,
    output trmt, tx_data, busy, byte_idx
  );
endinterface

// File: rtl/tx_byte_sequencer.sv
// Sends bytes from a small message buffer to the UART TX, one per request or a whole
// burst per request, advancing a wrapping pointer on each completed byte.
module tx_byte_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tx_byte_sequencer_if.slave   bus,
  output logic [1:0]           state_dbg
);

  // Handshake: send_next is a one-cycle request taken at a rising edge (queued one-deep
  // while busy); trmt is a one-cycle strobe with tx_data valid alongside and held;
  // tx_done is a one-cycle completion pulse, honoured only in WAIT once trmt is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          pend;
  logic          burst_l;
  logic          trmt_q;
  logic [7:0]    tx_data_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    mem [DEPTH];

  logic done_ok;
  logic at_last;
  logic burst_more;
  logic take_req;

  always_comb begin
    done_ok    = (state == WAIT) && bus.tx_done && !trmt_q;
    at_last    = (idx_q >= bus.last_idx);
    burst_more = burst_l && !at_last;
    take_req   = pend || bus.send_next;
    state_nxt  = state;
    case (state)
      IDLE:    if (bus.send_next) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (done_ok) state_nxt = (burst_more || take_req) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer has no reset so the message survives a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      burst_l   <= 1'b0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      idx_q     <= '0;
    end else begin
      state  <= state_nxt;
      trmt_q <= (state == LOAD);
      if (state == LOAD) tx_data_q <= mem[idx_q];
      if ((state == IDLE) && bus.send_next) burst_l <= bus.burst;
      if ((state != IDLE) && bus.send_next) pend <= 1'b1;
      if (done_ok) begin
        idx_q <= at_last ? '0 : idx_q + AW'(1);
        // A request consumed here (pending or arriving now) must not also leave pend set.
        if (!burst_more && take_req) begin
          pend    <= 1'b0;
          burst_l <= bus.burst;
        end
      end
    end
  end

  assign bus.trmt     = trmt_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != IDLE);
  assign bus.byte_idx = idx_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Self-checking bench for tx_byte_sequencer: table of single sends, then burst,
// pending/coincidence and reset-in-flight sequences, with a byte scoreboard on trmt.
module tb_tx_byte_sequencer;
  localparam int AW = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  always #10 clk = ~clk;

  tx_byte_sequencer_if #(.AW(AW)) bus();

  tx_byte_sequencer #(.DEPTH(8), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int         checks = 0;
  int         errors = 0;
  int         trmt_seen = 0;
  logic       prev_trmt = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [AW-1:0] last_idx;
    logic [7:0]    exp_data;
    logic [AW-1:0] exp_idx;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard: every trmt strobe must carry the next expected byte and last one cycle
  always @(negedge clk) begin
    if (rst_n && bus.trmt) begin
      trmt_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trmt: tx_data=%02h, required no strobe", bus.tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_data: got %02h, required %02h", bus.tx_data, mon_exp);
        end
      end
      checks++;
      if (prev_trmt) begin
        errors++;
        $display("FAIL trmt_width: trmt high 2+ cycles, required 1");
      end
    end
    prev_trmt = rst_n && bus.trmt;
  end

  // driver tasks: all drives happen just after a falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_send();
    bus.send_next = 1'b1;
    tick();
    bus.send_next = 1'b0;
  endtask

  task automatic do_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_trmt(input int target, output int lat);
    lat = 0;
    while (trmt_seen < target && lat < 50) begin
      tick();
      lat++;
    end
    if (trmt_seen < target) begin
      checks++;
      errors++;
      $display("FAIL trmt_timeout: seen %0d strobes, required %0d", trmt_seen, target);
    end
  endtask

  int base;
  int lat;

  initial begin
    bus.send_next = 1'b0; bus.burst = 1'b0; bus.last_idx = 3'd3;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00; bus.tx_done = 1'b0;

    vecs[0] = '{3'd3, 8'hA1, 3'd1};
    vecs[1] = '{3'd3, 8'hB2, 3'd2};
    vecs[2] = '{3'd3, 8'hC3, 3'd3};
    vecs[3] = '{3'd3, 8'hD4, 3'd0};
    vecs[4] = '{3'd3, 8'hA1, 3'd1};
    vecs[5] = '{3'd3, 8'hB2, 3'd2};
    vecs[6] = '{3'd3, 8'hC3, 3'd3};
    vecs[7] = '{3'd1, 8'hD4, 3'd0};  // last_idx shrunk below pointer: >= still wraps

    // reset state
    #35;
    check("rst_trmt", int'(bus.trmt), 0);
    check("rst_tx_data", int'(bus.tx_data), 8'h00);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_byte_idx", int'(bus.byte_idx), 0);
    check("rst_state", int'(state_dbg), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_no_trmt", trmt_seen, 0);

    wr_byte(3'd0, 8'hA1);
    wr_byte(3'd1, 8'hB2);
    wr_byte(3'd2, 8'hC3);
    wr_byte(3'd3, 8'hD4);

    // single sends with wrap
    for (int i = 0; i < 8; i++) begin
      bus.last_idx = vecs[i].last_idx;
      exp_q.push_back(vecs[i].exp_data);
      base = trmt_seen;
      pulse_send();
      wait_trmt(base + 1, lat);
      check("load_latency", lat, 1);
      check("busy_in_wait", int'(bus.busy), 1);
      repeat (10) tick();
      check("idx_held", int'(bus.byte_idx), int'(vecs[i].exp_idx == 3'd0 ? 3'd3 : vecs[i].exp_idx - 3'd1));
      do_done();
      check("byte_idx", int'(bus.byte_idx), int'(vecs[i].exp_idx));
      check("busy_after", int'(bus.busy), 0);
    end

    // burst from byte 0
    bus.last_idx = 3'd3;
    bus.burst = 1'b1;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    base = trmt_seen;
    pulse_send();
    for (int k = 0; k < 4; k++) begin
      wait_trmt(base + k + 1, lat);
      repeat (3) tick();
      do_done();
    end
    bus.burst = 1'b0;
    check("burst_busy_end", int'(bus.busy), 0);
    check("burst_idx_end", int'(bus.byte_idx), 0);
    repeat (5) tick();
    check("burst_count", trmt_seen - base, 4);

    // pending requests and tx_done coincident with trmt
    base = trmt_seen;
    exp_q.push_back(8'hA1);
    pulse_send();
    wait_trmt(base + 1, lat);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_send();
      tick();
    end
    exp_q.push_back(8'hB2);
    repeat (5) tick();
    check("early_done_idx", int'(bus.byte_idx), 0);
    check("early_done_busy", int'(bus.busy), 1);
    check("pend_no_early", trmt_seen - base, 1);
    do_done();
    check("pend_idx1", int'(bus.byte_idx), 1);
    wait_trmt(base + 2, lat);
    repeat (3) tick();
    do_done();
    check("pend_busy_end", int'(bus.busy), 0);
    check("pend_idx2", int'(bus.byte_idx), 2);
    repeat (10) tick();
    check("pend_count", trmt_seen - base, 2);

    // reset while waiting for tx_done
    exp_q.push_back(8'hC3);
    base = trmt_seen;
    pulse_send();
    wait_trmt(base + 1, lat);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_trmt", int'(bus.trmt), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_idx", int'(bus.byte_idx), 0);
    check("rst_mid_tx_data", int'(bus.tx_data), 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    do_done();
    check("late_done_busy", int'(bus.busy), 0);
    check("late_done_idx", int'(bus.byte_idx), 0);
    exp_q.push_back(8'hA1);
    base = trmt_seen;
    pulse_send();
    wait_trmt(base + 1, lat);
    repeat (3) tick();
    do_done();
    check("post_rst_idx", int'(bus.byte_idx), 1);
    check("post_rst_busy", int'(bus.busy), 0);

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_byte_sequencer.md
Name: tx_byte_sequencer

Overview:
- Sequences bytes from a small message buffer into the UART transmitter.
- Each `send_next` pulse from the pushbutton edge detector sends one byte. In burst mode, one pulse sends the remainder of the message.
- Issues a `trmt`/`tx_data` request to the transmitter, waits for `tx_done`, then advances a wrapping byte pointer.
- Sits between the pushbutton detector, the host-side buffer write port and the UART TX.

Parameters:
- DEPTH, 8, number of bytes in the message buffer.
- AW, 3, pointer/address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock (50 MHz); all block flops on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- send_next  input  1  one-cycle request pulse (from pushbutton detector, stable at posedge).
- burst  input  1  level; sampled with the accepted request; 1 = send through to last_idx.
- last_idx  input  AW  index of last valid byte in the message.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  AW  buffer write address.
- wr_data  input  8  buffer write data.
- tx_done  input  1  one-cycle pulse from UART TX: byte fully shifted out.
- trmt  output  1  registered one-cycle transmit strobe to UART TX.
- tx_data  output  8  registered byte for UART TX; held until next load.
- busy  output  1  high whenever state != IDLE.
- byte_idx  output  AW  current buffer pointer: next byte to send.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, byte_idx=0, trmt=0, tx_data=8'h00, busy=0.
  - pend=0, burst_l=0.
  - Buffer contents are not reset and are retained across reset.
- Buffer:
  - DEPTH x 8 registers; write on wr_en at posedge, accepted in any state.
  - A write to the address being sent after its LOAD cycle does not alter tx_data.
- States: IDLE, LOAD, WAIT.
- IDLE:
  - On send_next=1 at edge E0: latch burst_l<=burst, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (one cycle):
  - At edge E1: tx_data<=mem[byte_idx], trmt<=1, go to WAIT.
  - trmt and the new tx_data are therefore visible together in the cycle after E1: two edges after the request.
- WAIT:
  - trmt returns to 0 at the next edge; trmt is high for exactly one cycle per byte.
  - tx_done is honoured only when trmt=0. A tx_done coincident with the trmt-high cycle is ignored.
  - On an honoured tx_done:
    - If byte_idx >= last_idx: byte_idx<=0. Otherwise byte_idx<=byte_idx+1.
    - Next state:
      - burst_l=1 and old byte_idx < last_idx: go to LOAD; burst continues, no new request needed.
      - Else if pend=1 or send_next=1 this edge: clear pend, burst_l<=burst, go to LOAD.
      - Else: go to IDLE.
- Pending request:
  - send_next while state != IDLE sets pend (single-deep).
  - Multiple pulses while busy collapse into one extra byte.
  - pend is not set by a send_next that is consumed on the same edge.
- Burst termination: a burst stops after sending byte last_idx; byte_idx wraps to 0.
- last_idx changed mid-operation: takes effect at the next advance. The `>=` compare guarantees wrap even if byte_idx already exceeds the new last_idx.
- busy is combinational from state.
- byte_idx changes only on an honoured tx_done or on reset.
- Reset mid-operation: abandons the in-flight byte immediately. trmt drops asynchronously; a late tx_done after reset release is ignored (state IDLE).

Test Plan:
- Reset: hold rst_n=0 -> trmt=0, tx_data=8'h00, busy=0, byte_idx=0. Release, idle 5 cycles -> no trmt.
- Single send:
  - Stimulus: write mem[0..3]=A1,B2,C3,D4; last_idx=3; send_next pulse at edge E0.
  - Response: trmt=1 for one cycle after E1 with tx_data=A1; busy=1.
  - Then tx_done 10 cycles later -> byte_idx=1, busy=0 next cycle.
- Wrap: five single requests, each completed by tx_done -> tx_data sequence A1,B2,C3,D4,A1; byte_idx 1,2,3,0,1.
- Burst:
  - Stimulus: burst=1 with one send_next from byte_idx=0; tx_done returned for each byte.
  - Response: four trmt pulses carrying A1,B2,C3,D4; then IDLE, byte_idx=0, busy=0.
- Pending/coincidence:
  - Stimulus: three send_next pulses during WAIT, plus a tx_done in the trmt-high cycle.
  - Response: the early tx_done is ignored; after the real tx_done exactly one further byte (B2) is sent, then IDLE.
- Reset mid-WAIT:
  - Stimulus: rst_n low during WAIT.
  - Response: busy=0, byte_idx=0, trmt=0 immediately.
  - Then send_next after release -> tx_data=A1 (buffer retained).
